dmem_arbiter: RTL and testbench

- Shares the single-port data memory (2048 x 32, byte-addressed, combinational read, write on posedge clk) between two requesters.
- Port 0 is the CPU load/store unit; port 1 is the loader/DMA engine.
- Each port uses a req/ack handshake; simultaneous requests are resolved round-robin.
- Sits between the requesters and the data memory.
- Flags misaligned and out-of-range accesses and suppresses their writes.

---
 rtl/dmem_arbiter_pkg.sv | 13 +
 rtl/dmem_arbiter_rr_pick2.sv | 11 +
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared constants and FSM state type for the data-memory arbiter
package dmem_arbiter_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 32;
   localparam int DEPTH    = 2048;
   localparam int BYTE_LIM = DEPTH * 4;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_e;
endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin selector; on a tie the port that was not served last wins
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic valid,
   output logic winner
);
   assign valid  = req0 | req1;
   assign winner = (req0 & req1) ? ~last : req1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one single-port data memory between the LSU (port 0) and the loader (port 1)
module dmem_arbiter #(
   parameter int DATA_W = dmem_arbiter_pkg::DATA_W,
   parameter int ADDR_W = dmem_arbiter_pkg::ADDR_W,
   parameter int DEPTH  = dmem_arbiter_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wd0,
   input  logic [DATA_W-1:0] wd1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rd0,
   output logic [DATA_W-1:0] rd1,
   output logic              err0,
   output logic              err1,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd
);
   import dmem_arbiter_pkg::*;

   localparam logic [ADDR_W-1:0] LIM = ADDR_W'(DEPTH * 4);

   state_e            state_q, state_d;
   logic              last_q, last_d, port_q, port_d, we_q, we_d, err_q, err_d;
   logic              ack0_q, ack0_d, ack1_q, ack1_d, err0_q, err0_d, err1_q, err1_d;
   logic [ADDR_W-1:0] addr_q, addr_d, sel_addr;
   logic [DATA_W-1:0] wd_q, wd_d, rd0_q, rd0_d, rd1_q, rd1_d;
   logic              pick_valid, pick_win;

   rr_pick2 u_pick (
      .req0   (req0),
      .req1   (req1),
      .last   (last_q),
      .valid  (pick_valid),
      .winner (pick_win)
   );

   assign sel_addr = pick_win ? addr1 : addr0;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      port_d  = port_q;
      we_d    = we_q;
      err_d   = err_q;
      addr_d  = addr_q;
      wd_d    = wd_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      err0_d  = err0_q;
      err1_d  = err1_q;
      rd0_d   = rd0_q;
      rd1_d   = rd1_q;
      case (state_q)
         IDLE: if (pick_valid) begin
            state_d = ACCESS;
            port_d  = pick_win;
            we_d    = pick_win ? we1 : we0;
            addr_d  = sel_addr;
            wd_d    = pick_win ? wd1 : wd0;
            err_d   = (sel_addr[1:0] != 2'b00) || (sel_addr >= LIM);
         end
         ACCESS: begin
            state_d = DONE;
            last_d  = port_q;
            if (port_q) begin
               ack1_d = 1'b1;
               err1_d = err_q;
               rd1_d  = err_q ? '0 : mem_rd;
            end else begin
               ack0_d = 1'b1;
               err0_d = err_q;
               rd0_d  = err_q ? '0 : mem_rd;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         port_q  <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wd_q    <= '0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         err0_q  <= 1'b0;
         err1_q  <= 1'b0;
         rd0_q   <= '0;
         rd1_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         port_q  <= port_d;
         we_q    <= we_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wd_q    <= wd_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         err0_q  <= err0_d;
         err1_q  <= err1_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
      end
   end

   // reset gates the strobe combinationally so an abandoned access never writes
   assign mem_we = (state_q == ACCESS) & we_q & ~err_q & ~reset;
   assign mem_a  = addr_q;
   assign mem_wd = wd_q;
   assign ack0   = ack0_q;
   assign ack1   = ack1_q;
   assign err0   = err0_q;
   assign err1   = err1_q;
   assign rd0    = rd0_q;
   assign rd1    = rd1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter with a behavioural 2048x32 memory
module tb_dmem_arbiter;
   logic        clk = 1'b0, reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [31:0] addr0 = '0, addr1 = '0, wd0 = '0, wd1 = '0;
   logic        ack0, ack1, err0, err1, mem_we;
   logic [31:0] rd0, rd1, mem_a, mem_wd, mem_rd;
   logic [31:0] mem [0:2047];

   typedef struct packed {
      logic        p;
      logic [31:0] rd;
      logic        e;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0, failures = 0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk    (clk),
      .reset  (reset),
      .req0   (req0),
      .req1   (req1),
      .we0    (we0),
      .we1    (we1),
      .addr0  (addr0),
      .addr1  (addr1),
      .wd0    (wd0),
      .wd1    (wd1),
      .ack0   (ack0),
      .ack1   (ack1),
      .rd0    (rd0),
      .rd1    (rd1),
      .err0   (err0),
      .err1   (err1),
      .mem_a  (mem_a),
      .mem_we (mem_we),
      .mem_wd (mem_wd),
      .mem_rd (mem_rd)
   );

   assign mem_rd = (mem_a < 32'd8192) ? mem[mem_a[12:2]] : 32'h0;
   always @(posedge clk) if (mem_we) mem[mem_a[12:2]] <= mem_wd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (ack0 || ack1) begin
         if (exp_q.size() == 0) chk("unexpected_ack", {30'b0, ack1, ack0}, 32'h0);
         else begin
            mon_e = exp_q.pop_front();
            chk("ack_port", {31'b0, ack1}, {31'b0, mon_e.p});
            chk("rd", ack1 ? rd1 : rd0, mon_e.rd);
            chk("err", {31'b0, ack1 ? err1 : err0}, {31'b0, mon_e.e});
         end
      end
   end

   task automatic do_op(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input bit e, input bit late);
      int n = 0;
      bit we_seen = 1'b0;
      exp_q.push_back({p, exp_rd, e});
      if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wd1 = d; end
      else begin req0 = 1'b1; we0 = w; addr0 = a; wd0 = d; end
      do begin
         @(posedge clk); #1;
         n++;
         we_seen |= mem_we;
         if (late && n == 1) begin
            addr0 = a + 32'd4; wd0 = ~d;
            addr1 = a + 32'd4; wd1 = ~d;
         end
      end while (!(p ? ack1 : ack0) && n < 8);
      chk("latency", n, 2);
      chk("mem_we_seen", {31'b0, we_seen}, {31'b0, w && !e});
      req0 = 1'b0;
      req1 = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_flags", {27'b0, ack0, ack1, err0, err1, mem_we}, 32'h0);
      chk("reset_rd0", rd0, 32'h0);
      chk("reset_rd1", rd1, 32'h0);
      // both ports contend from the first cycle after reset
      reset = 1'b0;
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wd0 = 32'hA0A0_0001;
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h44; wd1 = 32'hB1B1_0002;
      exp_q.push_back({1'b0, 32'h0, 1'b0});
      exp_q.push_back({1'b1, 32'h0, 1'b0});
      exp_q.push_back({1'b0, 32'hA0A0_0001, 1'b0});
      exp_q.push_back({1'b1, 32'hB1B1_0002, 1'b0});
      for (int n = 1; n <= 11; n++) begin
         @(posedge clk); #1;
         chk("cont_ack0", {31'b0, ack0}, {31'b0, (n == 2 || n == 8)});
         chk("cont_ack1", {31'b0, ack1}, {31'b0, (n == 5 || n == 11)});
      end
      req0 = 1'b0;
      req1 = 1'b0;
      @(posedge clk); #1;
      do_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
      do_op(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
      do_op(1'b1, 1'b1, 32'h12, 32'h5, 32'h0, 1'b1, 1'b0);
      do_op(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
      do_op(1'b0, 1'b0, 32'h2000, 32'h0, 32'h0, 1'b1, 1'b0);
      do_op(1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h0, 1'b1, 1'b0);
      do_op(1'b1, 1'b1, 32'h1FFC, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
      do_op(1'b0, 1'b0, 32'h1FFC, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
      // reset lands in the ACCESS cycle of a write
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wd0 = 32'h1;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
      req0 = 1'b0;
      @(posedge clk); #1;
      chk("rst_ack0", {31'b0, ack0}, 32'h0);
      chk("rst_rd0", rd0, 32'h0);
      reset = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("post_rst_ack0", {31'b0, ack0}, 32'h0);
      end
      do_op(1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0);
      // late address/data change after grant must not affect the write
      do_op(1'b1, 1'b1, 32'h30, 32'h11, 32'h0, 1'b0, 1'b1);
      do_op(1'b1, 1'b0, 32'h30, 32'h0, 32'h11, 1'b0, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("idle_ack1", {31'b0, ack1}, 32'h0);
         chk("idle_mem_we", {31'b0, mem_we}, 32'h0);
         chk("rd1_hold", rd1, 32'h11);
      end
      do_op(1'b1, 1'b0, 32'h34, 32'h0, 32'h0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("queue_empty", exp_q.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
